// File: rtl/muldiv_unit_if.sv
// Register-file side request/write-back bundle of the iterative RV32M multiply/divide unit.
interface muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      op;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [4:0]      rd_addr;
   logic            busy;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;
   logic            wb_en;
   logic [4:0]      wb_addr;

   modport master (
      output start, op, rs1_data, rs2_data, rd_addr,
      input  busy, stall, done, result, wb_en, wb_addr
   );

   modport slave (
      input  start, op, rs1_data, rs2_data, rd_addr,
      output busy, stall, done, result, wb_en, wb_addr
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one radix-2 shift-add / restoring-divide step per cycle,
// magnitudes in CALC, sign fix-up in FIXUP, one-cycle write-back pulse in DONE.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic         clk,
   input  logic         rst,
   muldiv_unit_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_e;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

   state_e            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_op;
   logic [4:0]        r_wb_addr;
   logic [XLEN-1:0]   r_a, r_hi, r_lo, r_result;
   logic              r_neg, r_special;

   logic              w_sa, w_sb, w_neg, w_div0, w_ovf, w_special;
   logic [XLEN-1:0]   w_mag_a, w_mag_b, w_spec_val, w_fixed;
   logic [XLEN:0]     w_madd, w_dsub;
   logic [2*XLEN-1:0] w_prod_s;

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = w_special ? S_FIXUP : S_CALC;
         S_CALC:  if (r_cnt == LAST_STEP) w_state_nxt = S_FIXUP;
         S_FIXUP: w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
      bus.busy  = (r_state != S_IDLE);
      bus.stall = (bus.start && r_state == S_IDLE) || (r_state != S_IDLE);
      bus.done  = (r_state == S_DONE);
      bus.wb_en = (r_state == S_DONE) && (r_wb_addr != 5'd0);
   end

   assign bus.result  = r_result;
   assign bus.wb_addr = r_wb_addr;

   // Operand decode at acceptance: signedness, magnitudes and the 1-cycle special results
   always_comb begin
      w_sa       = bus.rs1_data[XLEN-1] && (bus.op == 3'd1 || bus.op == 3'd2 ||
                                            bus.op == 3'd4 || bus.op == 3'd6);
      w_sb       = bus.rs2_data[XLEN-1] && (bus.op == 3'd1 || bus.op == 3'd4 || bus.op == 3'd6);
      w_mag_a    = w_sa ? -bus.rs1_data : bus.rs1_data;
      w_mag_b    = w_sb ? -bus.rs2_data : bus.rs2_data;
      w_neg      = (bus.op == 3'd6) ? w_sa : (w_sa ^ w_sb);
      w_div0     = bus.op[2] && (bus.rs2_data == '0);
      w_ovf      = (bus.op == 3'd4 || bus.op == 3'd6) &&
                   (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_data == '1);
      w_special  = w_div0 || w_ovf;
      if (bus.op[1]) w_spec_val = w_div0 ? bus.rs1_data : '0;
      else           w_spec_val = w_div0 ? '1 : bus.rs1_data;
   end

   // One iteration: {r_hi,r_lo} is the product accumulator or the {remainder,dividend/quotient} pair
   always_comb begin
      w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
      w_dsub   = {r_hi, r_lo[XLEN-1]} - {1'b0, r_a};
      w_prod_s = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
      unique case (r_op)
         3'd0:             w_fixed = w_prod_s[XLEN-1:0];
         3'd1, 3'd2, 3'd3: w_fixed = w_prod_s[2*XLEN-1:XLEN];
         3'd4, 3'd5:       w_fixed = r_neg ? -r_lo : r_lo;
         default:          w_fixed = r_neg ? -r_hi : r_hi;
      endcase
      if (r_special) w_fixed = r_a;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt     <= '0;
         r_op      <= '0;
         r_wb_addr <= '0;
         r_a       <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_result  <= '0;
         r_neg     <= 1'b0;
         r_special <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: if (bus.start) begin
               r_op      <= bus.op;
               r_wb_addr <= bus.rd_addr;
               r_cnt     <= '0;
               r_neg     <= w_neg;
               r_special <= w_special;
               r_hi      <= '0;
               if (w_special) begin
                  r_a <= w_spec_val;
               end else if (bus.op[2]) begin
                  r_a  <= w_mag_b;
                  r_lo <= w_mag_a;
               end else begin
                  r_a  <= w_mag_a;
                  r_lo <= w_mag_b;
               end
            end
            S_CALC: begin
               r_cnt <= r_cnt + 1'b1;
               if (!r_op[2]) begin
                  r_hi <= w_madd[XLEN:1];
                  r_lo <= {w_madd[0], r_lo[XLEN-1:1]};
               end else if (!w_dsub[XLEN]) begin
                  r_hi <= w_dsub[XLEN-1:0];
                  r_lo <= {r_lo[XLEN-2:0], 1'b1};
               end else begin
                  r_hi <= {r_hi[XLEN-2:0], r_lo[XLEN-1]};
                  r_lo <= {r_lo[XLEN-2:0], 1'b0};
               end
            end
            S_FIXUP: r_result <= w_fixed;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table plus scoreboard of expected write-backs.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   muldiv_unit_if #(.XLEN(32)) bus ();

   muldiv_unit #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] want;
      int unsigned lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  addr;
      logic        en;
      int unsigned dcyc;
   } sb_t;

   vec_t        vecs[$];
   sb_t         sb[$];
   sb_t         mon_e;
   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned fails = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("result", bus.result, mon_e.res);
            chk("wb_addr", {27'd0, bus.wb_addr}, {27'd0, mon_e.addr});
            chk("wb_en", {31'd0, bus.wb_en}, {31'd0, mon_e.en});
            chk("done_cycle", cyc, mon_e.dcyc);
         end
      end
   end

   task automatic scramble();
      bus.rs1_data = $urandom;
      bus.rs2_data = $urandom;
      bus.rd_addr  = 5'($urandom);
      bus.op       = 3'($urandom);
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] want, input int unsigned lat,
                        output int unsigned c0);
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.rs1_data = a; bus.rs2_data = b; bus.rd_addr = rd;
      #1;
      chk("stall_req", {31'd0, bus.stall}, 32'd1);
      chk("busy_idle", {31'd0, bus.busy}, 32'd0);
      @(posedge clk);
      #1;
      c0 = cyc;
      sb.push_back('{res: want, addr: rd, en: (rd != 5'd0), dcyc: c0 + lat});
      bus.start = 1'b0;
      scramble();
      chk("busy_run", {31'd0, bus.busy}, 32'd1);
   endtask

   task automatic drain(input int unsigned budget);
      for (int unsigned i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
      chk("drain_pending", sb.size(), 32'd0);
      sb.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish by 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned c0;
      vecs.push_back('{3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33});
      vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 33});
      vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 33});
      vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 33});
      vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 33});
      vecs.push_back('{3'd3, 32'h8000_0000, 32'd4,         5'd6,  32'd2,         33});
      vecs.push_back('{3'd0, 32'd123,       32'd456,       5'd0,  32'h0000_DB18, 33});
      vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 33});
      vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 33});
      vecs.push_back('{3'd5, 32'd100,       32'd7,         5'd9,  32'd14,        33});
      vecs.push_back('{3'd7, 32'd100,       32'd7,         5'd10, 32'd2,         33});
      vecs.push_back('{3'd4, 32'd7,         32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, 33});
      vecs.push_back('{3'd6, 32'd7,         32'hFFFF_FFFE, 5'd12, 32'd1,         33});
      vecs.push_back('{3'd7, 32'hFFFF_FFFF, 32'd10,        5'd13, 32'd5,         33});
      vecs.push_back('{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         33});
      vecs.push_back('{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 33});
      vecs.push_back('{3'd5, 32'd5,         32'd0,         5'd16, 32'hFFFF_FFFF, 1});
      vecs.push_back('{3'd6, 32'd5,         32'd0,         5'd17, 32'd5,         1});
      vecs.push_back('{3'd4, 32'd5,         32'd0,         5'd18, 32'hFFFF_FFFF, 1});
      vecs.push_back('{3'd7, 32'd9,         32'd0,         5'd0,  32'd9,         1});
      vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1});
      vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'd0,         1});

      bus.start = 1'b0;
      scramble();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",    {31'd0, bus.busy},  32'd0);
      chk("rst_done",    {31'd0, bus.done},  32'd0);
      chk("rst_wb_en",   {31'd0, bus.wb_en}, 32'd0);
      chk("rst_stall",   {31'd0, bus.stall}, 32'd0);
      chk("rst_result",  bus.result,         32'd0);
      chk("rst_wb_addr", {27'd0, bus.wb_addr}, 32'd0);
      rst = 1'b1;

      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].want, vecs[i].lat, c0);
         drain(60);
      end

      // start pulsed mid-operation is ignored
      issue(3'd0, 32'd5, 32'd6, 5'd0, 32'd30, 33, c0);
      for (int unsigned i = 0; i < 40 && cyc < c0 + 10; i++) @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd5; bus.rs1_data = 32'd77; bus.rs2_data = 32'd3; bus.rd_addr = 5'd21;
      @(negedge clk);
      bus.start = 1'b0;
      drain(60);
      repeat (5) @(negedge clk);

      // start held high through busy and DONE: second op accepted only from IDLE
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd5; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7; bus.rd_addr = 5'd9;
      @(posedge clk);
      #1;
      c0 = cyc;
      sb.push_back('{res: 32'd14, addr: 5'd9, en: 1'b1, dcyc: c0 + 33});
      bus.op = 3'd6; bus.rs1_data = 32'hFFFF_FFF9; bus.rs2_data = 32'd2; bus.rd_addr = 5'd10;
      sb.push_back('{res: 32'hFFFF_FFFF, addr: 5'd10, en: 1'b1, dcyc: c0 + 68});
      for (int unsigned i = 0; i < 60 && cyc < c0 + 35; i++) @(negedge clk);
      bus.start = 1'b0;
      drain(80);

      // reset mid-divide aborts with no write-back
      issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 33, c0);
      for (int unsigned i = 0; i < 40 && cyc < c0 + 15; i++) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      sb.delete();
      chk("abort_busy",    {31'd0, bus.busy},    32'd0);
      chk("abort_done",    {31'd0, bus.done},    32'd0);
      chk("abort_wb_en",   {31'd0, bus.wb_en},   32'd0);
      chk("abort_result",  bus.result,           32'd0);
      chk("abort_wb_addr", {27'd0, bus.wb_addr}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);

      issue(3'd0, 32'd123, 32'd456, 5'd31, 32'h0000_DB18, 33, c0);
      drain(60);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
